// File: rtl/input_cond_pkg.sv
// Shared types and constants for the board input conditioner.
// Debounce counts must be >= 2 and fit in CNT_W bits (2**CNT_W >= DEBOUNCE_CYCLES).
package input_cond_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } dbnc_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int CNT_W_DEFAULT           = 19;

  localparam int CH_SW0  = 0;
  localparam int CH_SW1  = 1;
  localparam int CH_KEY0 = 2;
  localparam int CH_KEY1 = 3;

endpackage

// File: rtl/debounce_channel.sv
// One active-high input: 2-flop synchroniser, debounce FSM, registered level and edge pulses.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = CNT_W_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_log,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1, r_s2, r_stb, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;
  dbnc_state_t      r_state;

  logic             w_stb_nxt, w_rise_nxt, w_fall_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  dbnc_state_t      w_state_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_state <= STABLE;
      r_cnt   <= '0;
      r_stb   <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_s1    <= i_log;
      r_s2    <= r_s1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stb   <= w_stb_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Bounce check precedes expiry, so a reversion on the final count aborts the change.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stb_nxt   = r_stb;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      STABLE: begin
        if (r_s2 != r_stb) begin
          w_state_nxt = PENDING;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      PENDING: begin
        if (r_s2 == r_stb) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = STABLE;
          w_cnt_nxt   = '0;
          w_stb_nxt   = r_s2;
          w_rise_nxt  = r_s2;
          w_fall_nxt  = ~r_s2;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = STABLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level = r_stb;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Board switch/key conditioner: polarity normalisation then one debounce channel per pin.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int               CNT_W           = CNT_W_DEFAULT,
  parameter logic [WIDTH-1:0] ACTIVE_LOW      = 4'b1100
) (
  input  logic             MAX10_CLK1_50,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] pin_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  // Inverting ahead of the synchroniser keeps reset (0) equal to the inactive level.
  logic [WIDTH-1:0] w_log;
  assign w_log = pin_i ^ ACTIVE_LOW;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_ch (
      .i_clk   (MAX10_CLK1_50),
      .i_rst   (reset_reset),
      .i_log   (w_log[g]),
      .o_level (level_o[g]),
      .o_rise  (rise_o[g]),
      .o_fall  (fall_o[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scenarios plus random pin activity against a sliding-window debounce model.
module tb_input_conditioner;
  import input_cond_pkg::*;

  localparam int         DC = 8;
  localparam logic [3:0] AL = 4'b1100;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pin_i, level_o, rise_o, fall_o;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (DC),
    .CNT_W           (4),
    .ACTIVE_LOW      (AL)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset_reset   (rst),
    .pin_i         (pin_i),
    .level_o       (level_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o)
  );

  // Model: a channel flips once its last DC synchronised samples all disagree with its level.
  logic [3:0] m_s1 = '0, m_s2 = '0, m_level = '0, m_rise = '0, m_fall = '0;
  logic [3:0] hist[$];
  logic [3:0] lv, mr, mf;
  bit         all_new;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1 <= '0; m_s2 <= '0; m_level <= '0; m_rise <= '0; m_fall <= '0;
      hist.delete();
    end else begin
      hist.push_back(m_s2);
      if (hist.size() > DC) void'(hist.pop_front());
      lv = m_level; mr = '0; mf = '0;
      if (hist.size() == DC) begin
        for (int ch = 0; ch < 4; ch++) begin
          all_new = 1'b1;
          foreach (hist[i]) if (hist[i][ch] == m_level[ch]) all_new = 1'b0;
          if (all_new) begin
            lv[ch] = ~m_level[ch];
            if (lv[ch]) mr[ch] = 1'b1; else mf[ch] = 1'b1;
          end
        end
      end
      m_level <= lv; m_rise <= mr; m_fall <= mf;
      m_s2 <= m_s1;
      m_s1 <= pin_i ^ AL;
    end
  end

  task automatic test_reset();
    rst = 1'b1; pin_i = 4'b1100;
    repeat (3) begin
      @(negedge clk); total++;
      if ({level_o, rise_o, fall_o} !== 12'h000) begin
        bad++; $display("FAIL reset_hold: got %h want 000", {level_o, rise_o, fall_o});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk); total++;
      if ({level_o, rise_o, fall_o} !== 12'h000) begin
        bad++; $display("FAIL reset_quiet k=%0d: got %h want 000", k, {level_o, rise_o, fall_o});
      end
    end
  endtask

  task automatic test_key_press();
    for (int ph = 0; ph < 2; ph++) begin
      pin_i[CH_KEY0] = (ph == 1);
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk); total++;
        if (level_o[CH_KEY0] !== ((ph == 0) ? (k >= 10) : (k < 10)) ||
            rise_o[CH_KEY0]  !== (ph == 0 && k == 10) ||
            fall_o[CH_KEY0]  !== (ph == 1 && k == 10)) begin
          bad++; $display("FAIL key_latency ph=%0d k=%0d: got l=%b r=%b f=%b", ph, k,
                          level_o[CH_KEY0], rise_o[CH_KEY0], fall_o[CH_KEY0]);
        end
        total++;
        if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
          bad++; $display("FAIL key_model k=%0d: got %h want %h", k,
                          {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
        end
      end
    end
  endtask

  task automatic test_glitch();
    pin_i[CH_SW0] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 5) pin_i[CH_SW0] = 1'b0;
      total++;
      if ({level_o[CH_SW0], rise_o[CH_SW0], fall_o[CH_SW0]} !== 3'b000) begin
        bad++; $display("FAIL glitch k=%0d: got l=%b r=%b f=%b want 0 0 0", k,
                        level_o[CH_SW0], rise_o[CH_SW0], fall_o[CH_SW0]);
      end
    end
  endtask

  task automatic test_bounce_restart();
    pin_i[CH_SW1] = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); total++;
      if (level_o[CH_SW1] !== (k >= 18) || rise_o[CH_SW1] !== (k == 18) || fall_o[CH_SW1] !== 1'b0) begin
        bad++; $display("FAIL bounce_restart k=%0d: got l=%b r=%b f=%b want l=%b r=%b f=0", k,
                        level_o[CH_SW1], rise_o[CH_SW1], fall_o[CH_SW1], k >= 18, k == 18);
      end
      if (k == 7) pin_i[CH_SW1] = 1'b0;
      if (k == 8) pin_i[CH_SW1] = 1'b1;
    end
    pin_i[CH_SW1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); total++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        bad++; $display("FAIL bounce_model k=%0d: got %h want %h", k,
                        {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_reset_mid_pending();
    pin_i[CH_KEY1] = 1'b0;
    repeat (7) @(negedge clk);
    total++;
    if (level_o[CH_KEY1] !== 1'b0) begin
      bad++; $display("FAIL midpend_pre: got l=%b want 0", level_o[CH_KEY1]);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk); total++;
      if ({level_o, rise_o, fall_o} !== 12'h000) begin
        bad++; $display("FAIL midpend_reset: got %h want 000", {level_o, rise_o, fall_o});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); total++;
      if (level_o[CH_KEY1] !== (k >= 10) || rise_o[CH_KEY1] !== (k == 10)) begin
        bad++; $display("FAIL midpend_restart k=%0d: got l=%b r=%b want l=%b r=%b", k,
                        level_o[CH_KEY1], rise_o[CH_KEY1], k >= 10, k == 10);
      end
    end
    pin_i[CH_KEY1] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); total++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        bad++; $display("FAIL midpend_model k=%0d: got %h want %h", k,
                        {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_simultaneous();
    pin_i[CH_SW0] = 1'b1; pin_i[CH_KEY1] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk); total++;
      if (rise_o !== ((k == 10) ? 4'b1001 : 4'b0000) || fall_o !== 4'b0000 ||
          level_o !== ((k >= 10) ? 4'b1001 : 4'b0000)) begin
        bad++; $display("FAIL simultaneous k=%0d: got l=%b r=%b f=%b", k, level_o, rise_o, fall_o);
      end
    end
    pin_i = 4'b1100;
    repeat (20) @(negedge clk);
    total++;
    if (level_o !== 4'b0000) begin
      bad++; $display("FAIL simultaneous_release: got l=%b want 0000", level_o);
    end
  endtask

  task automatic test_random();
    int hold[4];
    for (int ch = 0; ch < 4; ch++) hold[ch] = $urandom_range(1, 14);
    for (int k = 0; k < 800; k++) begin
      @(negedge clk); total++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall} || (rise_o & fall_o) !== 4'b0000) begin
        bad++; $display("FAIL random k=%0d: got %h want %h", k,
                        {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
      for (int ch = 0; ch < 4; ch++) begin
        hold[ch]--;
        if (hold[ch] == 0) begin
          pin_i[ch] = ~pin_i[ch];
          hold[ch]  = $urandom_range(1, 14);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_key_press();
    test_glitch();
    test_bounce_restart();
    test_reset_mid_pending();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
